// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI read master.
//   rd_state_e : FSM state encoding (IDLE, AR, RD, DONE)
//   beat_shift : log2 of bytes per data beat, used to advance the burst address
// No ports; imported by axi_rd_burst_gen and axi_rd_master.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  function automatic int unsigned beat_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int unsigned BEAT_SHIFT = beat_shift(DEF_DATA_WIDTH);

endpackage

// File: rtl/axi_rd_master_if.sv
// AXI4 read address / read data channel bundle between the read master and
// the DDR2 controller's AXI slave port.
//   master modport : drives arvalid/araddr/arlen/rready, samples the rest
//   slave modport  : the mirror image
interface axi_rd_master_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic                  axi_rlast;

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_rready,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rlast
  );

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_rready,
    output axi_arready, axi_rvalid, axi_rdata, axi_rlast
  );
endinterface

// File: rtl/axi_rd_burst_gen.sv
// Burst sizing for the AXI read master (purely combinational).
//   remaining : beats still to be requested (1..256)
//   cur_addr  : start address of the burst currently on the bus
//   cur_arlen : arlen of the burst currently on the bus
//   arlen     : min(remaining, RBURST_LEN) - 1 for the next burst
//   next_addr : cur_addr advanced past the current burst, wrapping at 2^ADDR_WIDTH
module axi_rd_burst_gen
  import axi_rd_pkg::*;
#(
  parameter int          ADDR_WIDTH = 26,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RBURST_LEN = 8
) (
  input  logic [8:0]            remaining,
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [7:0]            cur_arlen,
  output logic [7:0]            arlen,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int unsigned SHIFT     = beat_shift(DATA_WIDTH);
  localparam logic [8:0]  BURST_MAX = 9'(RBURST_LEN);

  logic [8:0] beats;
  logic [8:0] cur_beats;

  always_comb begin
    beats     = (remaining > BURST_MAX) ? BURST_MAX : remaining;
    arlen     = 8'(beats - 9'd1);
    cur_beats = {1'b0, cur_arlen} + 9'd1;
    next_addr = cur_addr + (ADDR_WIDTH'(cur_beats) << SHIFT);
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 read initiator: splits one user request (start address, beat count)
// into AXI read bursts of at most RBURST_LEN beats and returns the data as a
// one-beat-per-strobe stream.
//   clk, rst              : clock, asynchronous active-high reset
//   init_end              : DDR2 init complete; requests ignored while low
//   rd_trig/rd_len/rd_addr: request (rd_len = beats - 1)
//   rd_ready              : idle, able to accept a request
//   rd_done               : one-cycle pulse after the final beat
//   rd_data/rd_data_en    : registered read data and its strobe
//   rd_err                : sticky rlast mismatch flag
//   axi                   : AXI read channels (master modport)
// Optional feature: define AXI_RD_LAST_CHK_EN to check axi_rlast against the
// internal beat counter; otherwise axi_rlast is ignored and rd_err is 0.
//
// state | meaning
// IDLE  | rd_ready high, waiting for rd_trig && init_end
// AR    | axi_arvalid high, address/length held until axi_arready
// RD    | axi_rready high, collecting the beats of one burst
// DONE  | request complete, rd_done is raised on the way back to IDLE
module axi_rd_master
  import axi_rd_pkg::*;
#(
  parameter int          ADDR_WIDTH = 26,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RBURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_err,
  axi_rd_master_if.master       axi
);

  rd_state_e             state;
  logic [8:0]            remaining;
  logic [7:0]            beat_cnt;
  logic [8:0]            gen_remaining;
  logic [7:0]            gen_arlen;
  logic [ADDR_WIDTH-1:0] gen_next_addr;
  logic                  beat;

  assign beat = axi.axi_rvalid && axi.axi_rready;

  // In IDLE the generator sizes the first burst from the incoming request;
  // in RD it sizes the follow-on burst from what is left after this beat.
  assign gen_remaining = (state == IDLE) ? ({1'b0, rd_len} + 9'd1)
                                         : (remaining - 9'd1);

  axi_rd_burst_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RBURST_LEN (RBURST_LEN)
  ) u_burst_gen (
    .remaining (gen_remaining),
    .cur_addr  (axi.axi_araddr),
    .cur_arlen (axi.axi_arlen),
    .arlen     (gen_arlen),
    .next_addr (gen_next_addr)
  );

`ifdef AXI_RD_LAST_CHK_EN
  logic err_q;
  assign rd_err = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = axi.axi_rlast;
  assign rd_err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      remaining       <= 9'd0;
      beat_cnt        <= 8'd0;
      axi.axi_arvalid <= 1'b0;
      axi.axi_araddr  <= '0;
      axi.axi_arlen   <= 8'd0;
      axi.axi_rready  <= 1'b0;
      rd_data         <= '0;
      rd_data_en      <= 1'b0;
      rd_done         <= 1'b0;
      rd_ready        <= 1'b1;
`ifdef AXI_RD_LAST_CHK_EN
      err_q           <= 1'b0;
`endif
    end else begin
      rd_data_en <= 1'b0;
      rd_done    <= 1'b0;
      case (state)
        IDLE: begin
          rd_ready <= 1'b1;
          // rd_ready is still low in the cycle that carries rd_done, so a
          // request is only taken once rd_ready is visible to the user.
          if (rd_ready && rd_trig && init_end) begin
            axi.axi_araddr  <= rd_addr;
            axi.axi_arlen   <= gen_arlen;
            axi.axi_arvalid <= 1'b1;
            remaining       <= gen_remaining;
            rd_ready        <= 1'b0;
`ifdef AXI_RD_LAST_CHK_EN
            err_q           <= 1'b0;
`endif
            state           <= AR;
          end
        end
        AR: begin
          if (axi.axi_arready) begin
            axi.axi_arvalid <= 1'b0;
            axi.axi_rready  <= 1'b1;
            beat_cnt        <= axi.axi_arlen;
            state           <= RD;
          end
        end
        RD: begin
          if (beat) begin
            rd_data    <= axi.axi_rdata;
            rd_data_en <= 1'b1;
            remaining  <= remaining - 9'd1;
            beat_cnt   <= beat_cnt - 8'd1;
`ifdef AXI_RD_LAST_CHK_EN
            if (axi.axi_rlast != (beat_cnt == 8'd0)) begin
              err_q <= 1'b1;
            end
`endif
            // Burst length is owned by our own counter; rlast never ends it.
            if (beat_cnt == 8'd0) begin
              axi.axi_rready <= 1'b0;
              if (gen_remaining != 9'd0) begin
                axi.axi_araddr  <= gen_next_addr;
                axi.axi_arlen   <= gen_arlen;
                axi.axi_arvalid <= 1'b1;
                state           <= AR;
              end else begin
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          rd_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
module tb_axi_rd_master;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int RBL = 8;
`ifdef AXI_RD_LAST_CHK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_end = 1'b0;
  logic          rd_trig = 1'b0;
  logic [7:0]    rd_len = 8'd0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready, rd_done, rd_data_en, rd_err;
  logic [DW-1:0] rd_data;

  axi_rd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_bus ();

  axi_rd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RBURST_LEN(RBL)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_end   (init_end),
    .rd_trig    (rd_trig),
    .rd_len     (rd_len),
    .rd_addr    (rd_addr),
    .rd_ready   (rd_ready),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .rd_data_en (rd_data_en),
    .rd_err     (rd_err),
    .axi        (axi_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  int checks = 0;
  int failures = 0;

  burst_t        exp_bursts[$];
  burst_t        sl_bursts[$];
  logic [DW-1:0] exp_data[$];

  int sl_idx = 0, ar_wait = 0, ar_delay = 0, rv_mode = 0, inj_at = -1;
  int req_beats = 0, req_n = 0, req_nb = 0;
  int ar_cnt = 0, de_cnt = 0, done_cnt = 0;
  int ar_base = 0, de_base = 0, done_base = 0;
  int neg_idx = 0, last_beat_neg = 0, done_neg = 0;
  bit rv_tog = 0, beat_prev = 0, end_prev = 0, more_prev = 0, hs_prev = 0, arv_prev = 0;
  logic [AW-1:0] araddr_prev = '0;
  logic [7:0]    arlen_prev = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave responder plus output monitor; works on the falling edge,
  // recording handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    bit arready_n, rvalid_n, rlast_n, hs, beat_n, end_n, more_n;
    logic [DW-1:0] rdata_n;
    burst_t b, e;
    neg_idx++;
    if (rst) begin
      sl_bursts.delete();
      sl_idx = 0; ar_wait = 0; rv_tog = 0;
      beat_prev = 0; end_prev = 0; more_prev = 0; hs_prev = 0; arv_prev = 0;
      axi_bus.axi_arready = 1'b0;
      axi_bus.axi_rvalid  = 1'b0;
      axi_bus.axi_rlast   = 1'b0;
      axi_bus.axi_rdata   = '0;
    end else begin
      if (rd_data_en) de_cnt++;
      if (beat_prev || rd_data_en) begin
        chk("rd_data_en_lag", rd_data_en, beat_prev);
        if (beat_prev && exp_data.size() > 0) chk("rd_data", rd_data, exp_data.pop_front());
      end
      if (end_prev) begin
        chk("rready_drop", axi_bus.axi_rready, 1'b0);
        chk("next_arvalid", axi_bus.axi_arvalid, more_prev);
      end
      if (rd_done) begin
        done_cnt++;
        done_neg = neg_idx;
      end
      if (arv_prev && !hs_prev && axi_bus.axi_arvalid) begin
        chk("araddr_stable", axi_bus.axi_araddr, araddr_prev);
        chk("arlen_stable", axi_bus.axi_arlen, arlen_prev);
      end

      if (axi_bus.axi_arvalid) ar_wait++;
      else ar_wait = 0;
      arready_n = axi_bus.axi_arvalid && (ar_wait > ar_delay);
      hs = arready_n && axi_bus.axi_arvalid;
      if (hs) begin
        ar_cnt++;
        if (exp_bursts.size() > 0) begin
          e = exp_bursts.pop_front();
          chk("araddr", axi_bus.axi_araddr, e.addr);
          chk("arlen", axi_bus.axi_arlen, e.len);
        end
        b.addr = axi_bus.axi_araddr;
        b.len  = axi_bus.axi_arlen;
        sl_bursts.push_back(b);
      end

      rvalid_n = 0; rlast_n = 0; rdata_n = '0;
      if (sl_bursts.size() > 0) begin
        case (rv_mode)
          0: rvalid_n = 1'b1;
          1: begin rv_tog = !rv_tog; rvalid_n = rv_tog; end
          default: rvalid_n = ($urandom_range(0, 3) != 0);
        endcase
        b = sl_bursts[0];
        rdata_n = mem_word(b.addr + AW'(sl_idx * (DW / 8)));
        rlast_n = (sl_idx == int'(b.len)) ^ (req_beats == inj_at);
      end
      beat_n = rvalid_n && axi_bus.axi_rready;
      end_n = 0; more_n = 0;
      if (beat_n) begin
        req_beats++;
        last_beat_neg = neg_idx;
        sl_idx++;
        if (sl_idx > int'(sl_bursts[0].len)) begin
          void'(sl_bursts.pop_front());
          sl_idx = 0;
          end_n  = 1;
          more_n = (exp_bursts.size() > 0);
        end
      end

      axi_bus.axi_arready = arready_n;
      axi_bus.axi_rvalid  = rvalid_n;
      axi_bus.axi_rlast   = rlast_n;
      axi_bus.axi_rdata   = rdata_n;
      beat_prev = beat_n; end_prev = end_n; more_prev = more_n; hs_prev = hs;
      arv_prev = axi_bus.axi_arvalid;
      araddr_prev = axi_bus.axi_araddr;
      arlen_prev = axi_bus.axi_arlen;
    end
  end

  // Reference: request splits into ceil(n/RBL) contiguous bursts and the data
  // stream is simply the n consecutive words starting at the request address.
  task automatic start_req(input logic [AW-1:0] a, input int len);
    int n, rem;
    burst_t b;
    n = len + 1;
    req_nb = 0;
    for (int k = 0; k * RBL < n; k++) begin
      rem = n - k * RBL;
      b.addr = a + AW'(k * RBL * (DW / 8));
      b.len  = 8'(((rem > RBL) ? RBL : rem) - 1);
      exp_bursts.push_back(b);
      req_nb++;
    end
    for (int i = 0; i < n; i++) exp_data.push_back(mem_word(a + AW'(i * (DW / 8))));
    req_n = n; req_beats = 0;
    ar_base = ar_cnt; de_base = de_cnt; done_base = done_cnt;
    chk("rd_ready_idle", rd_ready, 1'b1);
    rd_addr = a;
    rd_len  = 8'(len);
    rd_trig = 1'b1;
    @(negedge clk); #1;
    rd_trig = 1'b0;
    chk("arvalid_rise", axi_bus.axi_arvalid, 1'b1);
    chk("rd_ready_busy", rd_ready, 1'b0);
    chk("rd_err_clear", rd_err, 1'b0);
  endtask

  task automatic finish_req(input bit exp_err);
    bit seen;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk); #1;
      if (done_cnt != done_base) seen = 1;
    end
    chk("done_seen", seen, 1'b1);
    chk("done_timing", done_neg, last_beat_neg + 2);
    chk("beat_count", req_beats, req_n);
    chk("de_count", de_cnt - de_base, req_n);
    chk("ar_count", ar_cnt - ar_base, req_nb);
    chk("rd_ready_at_done", rd_ready, 1'b0);
    chk("rd_err", rd_err, exp_err);
    @(negedge clk); #1;
    chk("rd_ready_back", rd_ready, 1'b1);
    chk("rd_done_pulse", rd_done, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", done_cnt - done_base, 1);
    chk("rd_err_hold", rd_err, exp_err);
  endtask

  task automatic check_reset_vals();
    chk("rst_arvalid", axi_bus.axi_arvalid, 1'b0);
    chk("rst_araddr", axi_bus.axi_araddr, '0);
    chk("rst_arlen", axi_bus.axi_arlen, 8'd0);
    chk("rst_rready", axi_bus.axi_rready, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_rd_data_en", rd_data_en, 1'b0);
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b1);
  endtask

  task automatic wait_beats(input int k);
    for (int c = 0; c < 400 && req_beats < k; c++) begin
      @(negedge clk); #1;
    end
    chk("mid_beats_reached", (req_beats >= k), 1'b1);
  endtask

  initial begin
    int base;
    logic [AW-1:0] ra;
    axi_bus.axi_arready = 1'b0;
    axi_bus.axi_rvalid  = 1'b0;
    axi_bus.axi_rlast   = 1'b0;
    axi_bus.axi_rdata   = '0;

    repeat (3) @(negedge clk);
    #1 check_reset_vals();
    #1 rst = 1'b0;
    init_end = 1'b1;
    @(negedge clk); #1;

    // single full burst
    start_req(26'h100, 7);
    finish_req(1'b0);

    // three bursts, short tail
    start_req(26'h0, 19);
    finish_req(1'b0);

    // slow arready, rvalid toggling
    ar_delay = 5; rv_mode = 1;
    start_req(26'h40, 12);
    finish_req(1'b0);
    ar_delay = 0; rv_mode = 0;

    // address wrap at 2^ADDR_WIDTH
    start_req(26'h3FF_FFF0, 19);
    finish_req(1'b0);

    // rd_trig ignored while init_end low
    init_end = 1'b0;
    base = ar_cnt;
    rd_addr = 26'h500; rd_len = 8'd3; rd_trig = 1'b1;
    @(negedge clk); #1;
    rd_trig = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("no_ar_init_end", ar_cnt, base);
    chk("ready_init_end", rd_ready, 1'b1);
    chk("arvalid_init_end", axi_bus.axi_arvalid, 1'b0);
    init_end = 1'b1;

    // rd_trig ignored during RD
    start_req(26'h200, 15);
    wait_beats(3);
    rd_addr = 26'h777; rd_len = 8'd2; rd_trig = 1'b1;
    @(negedge clk); #1;
    rd_trig = 1'b0;
    finish_req(1'b0);

    // reset mid-burst
    start_req(26'h300, 15);
    wait_beats(5);
    rst = 1'b1;
    #1 check_reset_vals();
    exp_bursts.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    start_req(26'h3C0, 0);
    finish_req(1'b0);

    // rlast asserted early on beat 3 of 8
    inj_at = 2;
    start_req(26'h1000, 7);
    finish_req(EXP_ERR);
    inj_at = -1;
    start_req(26'h2000, 3);
    finish_req(1'b0);

    // randomized requests
    for (int t = 0; t < 8; t++) begin
      ra = AW'($urandom);
      ar_delay = $urandom_range(0, 3);
      rv_mode = $urandom_range(0, 2);
      start_req(ra, $urandom_range(0, 40));
      finish_req(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_rd_master.md
# axi_rd_master

AXI4 read-channel initiator that turns a single user read request (start address, beat count) into one or more AXI read bursts towards the DDR2 controller's AXI slave port, and returns the read data to the user side as a qualified beat stream. It is the read-direction counterpart of the write master and sits alongside it between user logic and the DDR2 controller's AXI front end.

## Interface
- ADDR_WIDTH, 26, AXI/user address width (byte address)
- DATA_WIDTH, 32, data width; power of two, ≥ 8
- RBURST_LEN, 8'd8, max beats per AXI burst (1..256)
- clk  in  1  clock; everything is synchronous to its rising edge
- rst  in  1  asynchronous, active-high reset
- init_end  in  1  DDR2 init complete; rd_trig is ignored while 0
- rd_trig  in  1  start request; sampled in IDLE only
- rd_len  in  8  total beats minus 1 (0 → 1 beat, 255 → 256 beats)
- rd_addr  in  ADDR_WIDTH  start byte address
- rd_ready  out  1  high in IDLE
- rd_done  out  1  one-cycle pulse after the final beat of the request
- rd_data  out  DATA_WIDTH  registered read data
- rd_data_en  out  1  rd_data valid strobe, one cycle per beat
- rd_err  out  1  sticky rlast-mismatch flag (see Configuration)
- axi_arvalid / axi_arready  out / in  1  address handshake
- axi_araddr  out  ADDR_WIDTH  burst start address
- axi_arlen  out  8  burst beats minus 1
- axi_rvalid / axi_rready  in / out  1  data handshake
- axi_rdata  in  DATA_WIDTH  read data
- axi_rlast  in  1  last beat of burst

## Operation
- States: IDLE, AR, RD, DONE.
- IDLE: rd_ready=1. When rd_trig && init_end: latch rd_addr, remaining = rd_len+1 (9-bit), go to AR.
- AR entry: beats = min(remaining, RBURST_LEN); axi_arlen = beats-1; axi_arvalid=1. Hold axi_araddr/axi_arlen stable until axi_arready. On handshake: axi_arvalid=0, beat counter = beats-1, go to RD.
- RD: axi_rready=1. Each axi_rvalid&&axi_rready is one beat: rd_data<=axi_rdata, rd_data_en<=1, counter decrements, remaining decrements.
- Burst end is decided by the beat counter reaching 0, never by axi_rlast. Then if remaining>0: axi_araddr += beats·(DATA_WIDTH/8) modulo 2^ADDR_WIDTH, go to AR; otherwise go to DONE.
- DONE: rd_done=1 for one cycle, then IDLE.
- rd_trig outside IDLE is ignored. Beats are not accepted outside RD because axi_rready is 0 there.
- Final burst is short when RBURST_LEN does not divide rd_len+1.
- Reset, including mid-transfer: all state cleared immediately; an in-flight AXI transaction is abandoned, since the DDR2 side is reset together.

## Timing
- Reset values: axi_arvalid=0, axi_araddr=0, axi_arlen=0, axi_rready=0, rd_data=0, rd_data_en=0, rd_done=0, rd_err=0, rd_ready=1.
- axi_arvalid rises the cycle after rd_trig is accepted.
- axi_rready rises the cycle after the AR handshake and drops the cycle after the last beat of the burst.
- rd_data/rd_data_en lag the AXI beat by exactly 1 cycle. There is no back-pressure from the user side; the user must sink one beat per cycle.
- Next burst's axi_arvalid rises the cycle after the previous burst's last beat.
- rd_done is high 2 cycles after the final AXI beat (1 cycle after the final rd_data_en).
- rd_ready is high again the cycle after rd_done.

## Configuration
- AXI_RD_LAST_CHK_EN defined: on each accepted beat, compare axi_rlast with (counter==0). On mismatch, rd_err<=1. rd_err stays set until the next accepted rd_trig clears it. Data flow is unaffected.
- Not defined: axi_rlast is ignored and rd_err is tied to 0.

## Structure
- Package axi_rd_pkg holds the state encoding (IDLE, AR, RD, DONE) and the byte-per-beat shift constant log2(DATA_WIDTH/8).
- One sub-module, axi_rd_burst_gen, computes the burst size (min(remaining, RBURST_LEN)), axi_arlen, and the next burst address. The top module holds the FSM, counters and data register.

## Test plan
- rd_addr=0x100, rd_len=7, RBURST_LEN=8, arready high → one burst, araddr=0x100, arlen=7; 8 rd_data_en pulses with data in order; rd_done 2 cycles after the 8th beat.
- rd_len=19, RBURST_LEN=8 → three bursts: araddr 0x0/0x20/0x40, arlen 7/7/3; 20 beats total; single rd_done.
- arready delayed 5 cycles, rvalid toggling 1-0-1 → araddr/arlen held stable while arvalid is high; exactly rd_len+1 beats, no duplicates or drops.
- rd_trig pulsed during RD, and with init_end=0 in IDLE → ignored in both cases; no extra AR.
- rst asserted mid-burst → all outputs at reset values in the same cycle; after release, a new rd_len=0 request issues arlen=0 and produces 1 beat.
- With AXI_RD_LAST_CHK_EN: rlast asserted on beat 3 of 8 → rd_err=1 and stays set; all 8 beats still delivered; next rd_trig clears rd_err.
